// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch stage with D-stage register and stall buffer
// A fetched word that cannot enter D because of a stall is parked in buf_q until the stall clears.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] NPC,
  input  logic        Stall,
  output logic        IM_Req,
  output logic [31:0] IM_Addr,
  input  logic        IM_Ready,
  input  logic [31:0] IM_RData,
  output logic [31:0] InstrD,
  output logic [31:0] PCD,
  output logic [31:0] PCplus4D,
  output logic        ValidD
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pcf_q, pcf_d;
  logic [31:0] npcr_q, npcr_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pcd_q, pcd_d;
  logic [31:0] buf_q, buf_d;
  logic        valid_q, valid_d;

  logic        xfer;
  logic        d_load;
  logic [31:0] sel_pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = FETCH;
      FETCH:   if (xfer && Stall) state_d = HOLD;
      HOLD:    if (!Stall) state_d = FETCH;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    IM_Req = (state_q == FETCH);
  end

  assign xfer   = IM_Req && IM_Ready;
  assign d_load = !Stall && (xfer || (state_q == HOLD));
  // NPC only steers fetch while D holds a real, non-stalled instruction.
  assign sel_pc = (valid_q && !Stall) ? NPC : npcr_q;

  always_comb begin
    pcf_d   = pcf_q;
    npcr_d  = npcr_q;
    instr_d = instr_q;
    pcd_d   = pcd_q;
    buf_d   = buf_q;
    valid_d = valid_q;

    if (xfer && Stall) begin
      buf_d = IM_RData;
    end

    if (d_load) begin
      instr_d = (state_q == HOLD) ? buf_q : IM_RData;
      pcd_d   = pcf_q;
      valid_d = 1'b1;
      pcf_d   = sel_pc;
      npcr_d  = sel_pc + 32'd4;
    end else begin
      if (state_q == FETCH && !IM_Ready && !Stall) begin
        instr_d = 32'd0;
        pcd_d   = 32'd0;
        valid_d = 1'b0;
      end
      // Keep a branch target alive across memory wait states.
      if (valid_q && !Stall) begin
        npcr_d = NPC;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcf_q   <= RESET_PC;
      npcr_q  <= RESET_PC + 32'd4;
      instr_q <= 32'd0;
      pcd_q   <= 32'd0;
      buf_q   <= 32'd0;
      valid_q <= 1'b0;
    end else begin
      pcf_q   <= pcf_d;
      npcr_q  <= npcr_d;
      instr_q <= instr_d;
      pcd_q   <= pcd_d;
      buf_q   <= buf_d;
      valid_q <= valid_d;
    end
  end

  assign IM_Addr  = pcf_q;
  assign InstrD   = instr_q;
  assign PCD      = pcd_q;
  assign PCplus4D = pcd_q + 32'd4;
  assign ValidD   = valid_q;

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - scoreboard bench for fetch_stage
// Stimulus pushes expected post-edge outputs; a monitor pops and compares one entry per cycle.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] NPC;
  logic        Stall;
  logic        IM_Ready;
  logic [31:0] IM_RData;
  logic        IM_Req;
  logic [31:0] IM_Addr;
  logic [31:0] InstrD;
  logic [31:0] PCD;
  logic [31:0] PCplus4D;
  logic        ValidD;

  always #5 clk = ~clk;

  fetch_stage #(.RESET_PC(32'h0000_3000)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .NPC      (NPC),
    .Stall    (Stall),
    .IM_Req   (IM_Req),
    .IM_Addr  (IM_Addr),
    .IM_Ready (IM_Ready),
    .IM_RData (IM_RData),
    .InstrD   (InstrD),
    .PCD      (PCD),
    .PCplus4D (PCplus4D),
    .ValidD   (ValidD)
  );

  typedef struct packed {
    logic        req;
    logic [31:0] addr;
    logic        valid;
    logic [31:0] instr;
    logic [31:0] pcd;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  // Reference model: "started" = left post-reset idle cycle, "has_buf" = word parked behind a stall.
  logic        started, has_buf, m_valid;
  logic [31:0] m_pcf, m_nxt, m_instr, m_pcd, m_buf;

  function automatic logic [31:0] imem(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hC3C3_0F0F;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic step(input logic rst, input logic st, input logic rdy, input logic [31:0] npc);
    logic [31:0] sel, word;
    logic        load, was_valid;
    exp_t        e;
    @(negedge clk);
    rst_n    = rst;
    Stall    = st;
    IM_Ready = rdy;
    NPC      = npc;
    IM_RData = rdy ? imem(m_pcf) : $urandom;
    if (!rst) begin
      started = 0; has_buf = 0; m_valid = 0;
      m_pcf = 32'h3000; m_nxt = 32'h3004;
      m_instr = 0; m_pcd = 0; m_buf = 0;
    end else begin
      was_valid = m_valid;
      sel  = (m_valid && !st) ? npc : m_nxt;
      load = 0;
      word = 0;
      if (!started) begin
        started = 1;
      end else if (has_buf) begin
        if (!st) begin load = 1; word = m_buf; has_buf = 0; end
      end else if (rdy) begin
        if (!st) begin load = 1; word = IM_RData; end
        else begin m_buf = IM_RData; has_buf = 1; end
      end else if (!st) begin
        m_valid = 0; m_instr = 0; m_pcd = 0;
      end
      if (load) begin
        m_instr = word; m_pcd = m_pcf; m_valid = 1;
        m_pcf = sel; m_nxt = sel + 32'd4;
      end else if (was_valid && !st) begin
        m_nxt = npc;
      end
    end
    e.req   = started && !has_buf;
    e.addr  = m_pcf;
    e.valid = m_valid;
    e.instr = m_instr;
    e.pcd   = m_pcd;
    exp_q.push_back(e);
  endtask

  task automatic peek();
    @(posedge clk);
    #2;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req"},   IM_Req,   0);
    chk({tag, "_addr"},  IM_Addr,  32'h3000);
    chk({tag, "_valid"}, ValidD,   0);
    chk({tag, "_instr"}, InstrD,   0);
    chk({tag, "_pcd"},   PCD,      0);
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        mon_e = exp_q.pop_front();
        chk("mon_req",    IM_Req,   mon_e.req);
        chk("mon_addr",   IM_Addr,  mon_e.addr);
        chk("mon_valid",  ValidD,   mon_e.valid);
        chk("mon_instr",  InstrD,   mon_e.instr);
        chk("mon_pcd",    PCD,      mon_e.pcd);
        chk("mon_pcp4",   PCplus4D, mon_e.pcd + 32'd4);
      end
    end
  end

  initial begin
    rst_n = 0; Stall = 0; IM_Ready = 0; NPC = 0; IM_RData = 0;
    started = 0; has_buf = 0; m_valid = 0;
    m_pcf = 32'h3000; m_nxt = 32'h3004; m_instr = 0; m_pcd = 0; m_buf = 0;

    // Straight-line fetch, then a taken branch with its delay slot.
    step(0, 0, 1, 0); #1; chk_reset_outputs("rst0");
    step(1, 0, 1, $urandom); peek();
    chk("idle_req", IM_Req, 1); chk("idle_addr", IM_Addr, 32'h3000);
    step(1, 0, 1, $urandom); peek();
    chk("seq_addr1", IM_Addr, 32'h3004); chk("seq_pcd1", PCD, 32'h3000); chk("seq_valid1", ValidD, 1);
    step(1, 0, 1, m_pcd + 8); peek();
    chk("seq_addr2", IM_Addr, 32'h3008); chk("seq_pcd2", PCD, 32'h3004);
    step(1, 0, 1, 32'h3100); peek();
    chk("br_pcd", PCD, 32'h3008); chk("br_addr", IM_Addr, 32'h3100); chk("br_instr", InstrD, imem(32'h3008));
    step(1, 0, 1, m_pcd + 8);

    // Branch behind memory wait states, then a stalled transfer into the buffer.
    step(0, 0, 0, 0);
    step(1, 0, 1, $urandom);
    step(1, 0, 1, $urandom);
    step(1, 0, 1, m_pcd + 8);
    step(1, 0, 0, 32'h3100); peek();
    chk("wait_bubble", ValidD, 0); chk("wait_pcd", PCD, 0);
    step(1, 0, 0, $urandom);
    step(1, 0, 0, $urandom); peek();
    chk("wait_addr", IM_Addr, 32'h3008);
    step(1, 1, 1, $urandom); peek();
    chk("hold_req", IM_Req, 0); chk("hold_valid", ValidD, 0);
    step(1, 1, 0, $urandom); peek();
    chk("hold_req2", IM_Req, 0);
    step(1, 0, 0, $urandom); peek();
    chk("unhold_instr", InstrD, imem(32'h3008)); chk("unhold_pcd", PCD, 32'h3008);
    chk("unhold_addr", IM_Addr, 32'h3100); chk("unhold_req", IM_Req, 1);

    // Reset while holding a buffered word.
    step(1, 1, 1, m_pcd + 8); peek();
    chk("hold2_req", IM_Req, 0);
    step(0, 1, 1, $urandom); #1; chk_reset_outputs("rst_hold");
    step(1, 0, 1, $urandom); peek();
    chk("restart_addr", IM_Addr, 32'h3000); chk("restart_req", IM_Req, 1);

    for (int i = 0; i < 3000; i++) begin
      logic [31:0] npc_r;
      logic        rst_r;
      rst_r = ($urandom_range(0, 149) != 0);
      if (m_valid && $urandom_range(0, 4) != 0) npc_r = m_pcd + 32'd8;
      else if ($urandom_range(0, 3) == 0)       npc_r = 32'hFFFF_FFF8;
      else                                      npc_r = $urandom & 32'hFFFF_FFFC;
      step(rst_r, $urandom_range(0, 3) == 0, $urandom_range(0, 99) < 65, npc_r);
    end

    repeat (3) @(posedge clk);
    #2;
    chk("queue_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
